// File: rtl/if_hazard_ctrl_pkg.sv
// Shared definitions for the instruction-fetch hazard controller.
package if_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CNT_W      = 3;

  // A taken EX branch is older than the ID jump, so it always wins.
  function automatic logic [31:0] redirect_target(input logic        br,
                                                  input logic [31:0] br_pc,
                                                  input logic [31:0] jmp_pc);
    return br ? br_pc : jmp_pc;
  endfunction

endpackage

// File: rtl/if_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX load destination.
module if_hazard_ctrl_hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_use_rs && (id_rs == ex_rd);
    rt_match = id_use_rt && (id_rt == ex_rd);
    hazard   = ex_mem_read && (ex_rd != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/if_hazard_ctrl.sv
// Fetch sequencing controller: load-use bubbles, jump/branch redirects, memory wait.
// Define IF_HAZARD_PERF_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module if_hazard_ctrl
  import if_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REG_AW            = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              id_jump,
  input  logic [31:0]       id_jump_target,
  input  logic              ex_br_taken,
  input  logic [31:0]       ex_br_target,
  input  logic              mem_busy,
  output logic              stall,
  output logic              cond,
  output logic [31:0]       condNPC,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex
`ifdef IF_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] LS_INIT  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic             LS_MULTI = (LOAD_STALL_CYCLES > 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid;
  logic             pend_br;
  logic [31:0]      pend_pc;

  logic             hazard;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             load_stall_req;

  if_hazard_ctrl_hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  // MEM_WAIT with mem_busy low behaves exactly like RUN, so hazards and
  // redirects in the release cycle are handled without an extra bubble.
  always_comb begin
    redirect       = ex_br_taken || id_jump;
    redirect_pc    = redirect_target(ex_br_taken, ex_br_target, id_jump_target);
    load_stall_req = hazard && !ex_br_taken && !mem_busy;

    if (state == ST_LOAD_STALL) begin
      stall = 1'b1;
    end else begin
      stall = mem_busy || (hazard && !ex_br_taken);
    end
    stall_id = stall;

    cond    = !stall && (redirect || pend_valid);
    condNPC = '0;
    if (cond) begin
      condNPC = redirect ? redirect_pc : pend_pc;
    end
    flush_id = cond;
    flush_ex = (state == ST_LOAD_STALL) || load_stall_req || (!stall && ex_br_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_br    <= 1'b0;
      pend_pc    <= RESET_PC;
    end else begin
      case (state)
        ST_LOAD_STALL: begin
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= mem_busy ? ST_MEM_WAIT : ST_RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          if (mem_busy) begin
            state <= ST_MEM_WAIT;
          end else if (load_stall_req && LS_MULTI) begin
            state <= ST_LOAD_STALL;
            cnt   <= LS_INIT;
          end else begin
            state <= ST_RUN;
          end
        end
      endcase

      // A held jump is younger than a pending branch and must not replace it.
      if (stall) begin
        if (ex_br_taken) begin
          pend_valid <= 1'b1;
          pend_br    <= 1'b1;
          pend_pc    <= ex_br_target;
        end else if (id_jump && !(pend_valid && pend_br)) begin
          pend_valid <= 1'b1;
          pend_br    <= 1'b0;
          pend_pc    <= id_jump_target;
        end
      end else begin
        pend_valid <= 1'b0;
        pend_br    <= 1'b0;
      end
    end
  end

`ifdef IF_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (cond) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Scoreboard bench for if_hazard_ctrl: one instance with 1 load bubble, one with 3.
module tb_if_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_mem_read, id_jump, ex_br_taken, mem_busy;
  logic [31:0] id_jump_target, ex_br_target;

  logic        s1, c1, sid1, fid1, fex1;
  logic [31:0] n1;
  logic        s3, c3, sid3, fid3, fex3;
  logic [31:0] n3;
`ifdef IF_HAZARD_PERF_EN
  logic [31:0] p1s, p1f, p3s, p3f;
`endif

  if_hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .mem_busy(mem_busy),
    .stall(s1), .cond(c1), .condNPC(n1), .stall_id(sid1), .flush_id(fid1), .flush_ex(fex1)
`ifdef IF_HAZARD_PERF_EN
    , .perf_stall_cnt(p1s), .perf_flush_cnt(p1f)
`endif
  );

  if_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .mem_busy(mem_busy),
    .stall(s3), .cond(c3), .condNPC(n3), .stall_id(sid3), .flush_id(fid3), .flush_ex(fex3)
`ifdef IF_HAZARD_PERF_EN
    , .perf_stall_cnt(p3s), .perf_flush_cnt(p3f)
`endif
  );

  typedef struct {
    string       name;
    bit          sel3;
    bit          chkperf;
    logic        stall;
    logic        cond;
    logic [31:0] npc;
    logic        fid;
    logic        fex;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  bit   chk = 0;
  bit   use3 = 0;
  bit   chkperf = 0;

  exp_t        me;
  logic        a_s, a_c, a_sid, a_fid, a_fex;
  logic [31:0] a_n;

  always @(negedge clk) begin
    if (chk) begin
      nvec++;
      if (q.size() == 0) begin
        nmis++;
        $display("FAIL scoreboard_underflow: output presented, expected entry none");
      end else begin
        me    = q.pop_front();
        a_s   = me.sel3 ? s3   : s1;
        a_c   = me.sel3 ? c3   : c1;
        a_n   = me.sel3 ? n3   : n1;
        a_sid = me.sel3 ? sid3 : sid1;
        a_fid = me.sel3 ? fid3 : fid1;
        a_fex = me.sel3 ? fex3 : fex1;
        if ({a_s, a_c, a_n, a_sid, a_fid, a_fex} !==
            {me.stall, me.cond, me.npc, me.stall, me.fid, me.fex}) begin
          nmis++;
          $display("FAIL %s: got stall=%b cond=%b condNPC=%h stall_id=%b flush_id=%b flush_ex=%b, want stall=%b cond=%b condNPC=%h stall_id=%b flush_id=%b flush_ex=%b",
                   me.name, a_s, a_c, a_n, a_sid, a_fid, a_fex,
                   me.stall, me.cond, me.npc, me.stall, me.fid, me.fex);
        end
        if (me.chkperf) begin
`ifdef IF_HAZARD_PERF_EN
          nvec++;
          if ({p3s, p3f} !== 64'd0) begin
            nmis++;
            $display("FAIL %s_perf: got stall_cnt=%0d flush_cnt=%0d, want 0 0", me.name, p3s, p3f);
          end
`endif
        end
      end
    end
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0;
    id_jump = 1'b0; id_jump_target = '0;
    ex_br_taken = 1'b0; ex_br_target = '0;
    mem_busy = 1'b0;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs);
    ex_mem_read = 1'b1; ex_rd = rd; id_use_rs = 1'b1; id_rs = rs;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input string nm, input logic s, input logic c,
                      input logic [31:0] npc, input logic fid, input logic fex);
    exp_t e;
    e.name = nm; e.sel3 = use3; e.chkperf = chkperf;
    e.stall = s; e.cond = c; e.npc = npc; e.fid = fid; e.fex = fex;
    q.push_back(e);
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1; idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_state", 0, 0, 32'h0, 0, 0);

    // Load-use detection boundaries
    ld(5'd5, 5'd5);                          step("load_use_rs",      1, 0, 32'h0, 0, 1);
    idle();                                  step("load_use_release", 0, 0, 32'h0, 0, 0);
    ld(5'd0, 5'd0);                          step("load_use_rd0",     0, 0, 32'h0, 0, 0);
    idle(); ex_mem_read = 1; ex_rd = 5'd7; id_use_rt = 1; id_rt = 5'd7;
                                             step("load_use_rt",      1, 0, 32'h0, 0, 1);
    idle(); ex_mem_read = 1; ex_rd = 5'd9; id_rs = 5'd9;
                                             step("no_use_flag",      0, 0, 32'h0, 0, 0);
    idle(); ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1;
                                             step("not_a_load",       0, 0, 32'h0, 0, 0);

    // Zero-latency redirects in RUN
    idle(); ex_br_taken = 1; ex_br_target = 32'h40;
                                             step("branch",           0, 1, 32'h40, 1, 1);
    idle();                                  step("branch_next",      0, 0, 32'h0, 0, 0);
    id_jump = 1; id_jump_target = 32'h300;   step("jump",             0, 1, 32'h300, 1, 0);
    ex_br_taken = 1; ex_br_target = 32'h44; id_jump_target = 32'h500;
                                             step("branch_over_jump", 0, 1, 32'h44, 1, 1);
    idle(); ld(5'd5, 5'd5); ex_br_taken = 1; ex_br_target = 32'h80;
                                             step("branch_hazard",    0, 1, 32'h80, 1, 1);
    idle();                                  step("branch_hazard_nx", 0, 0, 32'h0, 0, 0);

    // Jump held across memory wait
    mem_busy = 1;                            step("memwait_c1",       1, 0, 32'h0, 0, 0);
    id_jump = 1; id_jump_target = 32'h100;   step("memwait_c2_jump",  1, 0, 32'h0, 0, 0);
    id_jump = 0;                             step("memwait_c3",       1, 0, 32'h0, 0, 0);
    idle();                                  step("memwait_release",  0, 1, 32'h100, 1, 0);
                                             step("memwait_after",    0, 0, 32'h0, 0, 0);

    // Branch overwrites a pending jump; a held jump does not overwrite the branch
    mem_busy = 1; id_jump = 1; id_jump_target = 32'h100;
                                             step("pend_jump",        1, 0, 32'h0, 0, 0);
    id_jump = 0; ex_br_taken = 1; ex_br_target = 32'h200;
                                             step("pend_branch",      1, 0, 32'h0, 0, 0);
    ex_br_taken = 0; id_jump = 1; id_jump_target = 32'h100;
                                             step("pend_jump_again",  1, 0, 32'h0, 0, 0);
    idle();                                  step("pend_release",     0, 1, 32'h200, 1, 0);
                                             step("pend_cleared",     0, 0, 32'h0, 0, 0);
    mem_busy = 1; id_jump = 1; id_jump_target = 32'h100;
                                             step("pend_jump2",       1, 0, 32'h0, 0, 0);
    idle(); ex_br_taken = 1; ex_br_target = 32'h240;
                                             step("release_new_redir",0, 1, 32'h240, 1, 1);
    idle();                                  step("release_new_clr",  0, 0, 32'h0, 0, 0);

    // Three-bubble instance: counted stall, memory extension, reset mid-stall
    rst = 1; rst3 = 0; use3 = 1;
    ld(5'd5, 5'd5);                          step("ls3_c1",           1, 0, 32'h0, 0, 1);
    idle();                                  step("ls3_c2",           1, 0, 32'h0, 0, 1);
                                             step("ls3_c3",           1, 0, 32'h0, 0, 1);
                                             step("ls3_done",         0, 0, 32'h0, 0, 0);
    ld(5'd5, 5'd5);                          step("ls3_mem_c1",       1, 0, 32'h0, 0, 1);
    idle();                                  step("ls3_mem_c2",       1, 0, 32'h0, 0, 1);
    mem_busy = 1;                            step("ls3_mem_c3",       1, 0, 32'h0, 0, 1);
                                             step("ls3_mem_wait",     1, 0, 32'h0, 0, 0);
    mem_busy = 0;                            step("ls3_mem_release",  0, 0, 32'h0, 0, 0);
    ld(5'd5, 5'd5);                          step("rst_c1",           1, 0, 32'h0, 0, 1);
    idle(); ex_br_taken = 1; ex_br_target = 32'h80;
                                             step("rst_pend_branch",  1, 0, 32'h0, 0, 1);
    idle(); rst3 = 1;                        tick();
    rst3 = 0; chkperf = 1;                   step("rst_mid_stall",    0, 0, 32'h0, 0, 0);
    chkperf = 0;                             step("rst_after",        0, 0, 32'h0, 0, 0);

    @(negedge clk);
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
